// File: rtl/mtip_if_cfg.sv
// Shared FC-1 receive configuration: ordered-set encodings, primitive bit map,
// class codes and the SOF/EOF delimiter table used by the primitive detector.
package mtip_if_cfg;

  localparam int unsigned FC1_WORD_W = 32;
  localparam int unsigned PRIM_W     = 12;
  localparam int unsigned CNT_W      = 3;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Primitive signals and sequences (K28.5 in the first byte)
  localparam logic [31:0] OS_IDLE  = 32'hBC95B5B5;
  localparam logic [31:0] OS_R_RDY = 32'hBC954A4A;
  localparam logic [31:0] OS_NOS   = 32'hBC55BF45;
  localparam logic [31:0] OS_OLS   = 32'hBC358A55;
  localparam logic [31:0] OS_LR    = 32'hBC49BF49;
  localparam logic [31:0] OS_LRR   = 32'hBC35BF49;
  localparam logic [31:0] OS_LIP   = 32'hBC15F7F7;

  // Bit positions in the primitive vector; bits 7..11 are reserved
  localparam int unsigned MTIP_PRIM_IDLE  = 0;
  localparam int unsigned MTIP_PRIM_R_RDY = 1;
  localparam int unsigned MTIP_PRIM_NOS   = 2;
  localparam int unsigned MTIP_PRIM_OLS   = 3;
  localparam int unsigned MTIP_PRIM_LR    = 4;
  localparam int unsigned MTIP_PRIM_LRR   = 5;
  localparam int unsigned MTIP_PRIM_LIP   = 6;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_IDLE  = 3'd1,
    CLS_R_RDY = 3'd2,
    CLS_NOS   = 3'd3,
    CLS_OLS   = 3'd4,
    CLS_LR    = 3'd5,
    CLS_LRR   = 3'd6,
    CLS_LIP   = 3'd7
  } fc1OsClass_t;

  // Frame delimiters, both running disparities where the encoding differs
  localparam int unsigned NUM_DELIM = 14;
  localparam logic [31:0] FC1_DELIM [NUM_DELIM] = '{
    32'hBCB51717,  // SOFc1
    32'hBCB55757,  // SOFi1
    32'hBCB53737,  // SOFn1
    32'hBCB55555,  // SOFi2
    32'hBCB53535,  // SOFn2
    32'hBCB55656,  // SOFi3
    32'hBCB53636,  // SOFn3
    32'hBCB55858,  // SOFf
    32'hBC957575,  // EOFt  RD-
    32'hBCB57575,  // EOFt  RD+
    32'hBC95D5D5,  // EOFdt RD-
    32'hBCB5D5D5,  // EOFdt RD+
    32'hBC95F5F5,  // EOFa  RD-
    32'hBCB5F5F5   // EOFa  RD+
  };

  function automatic logic isSeqClass(input fc1OsClass_t cls);
    return (cls == CLS_NOS) || (cls == CLS_OLS) || (cls == CLS_LR) ||
           (cls == CLS_LRR) || (cls == CLS_LIP);
  endfunction

  function automatic logic [3:0] primIndex(input fc1OsClass_t cls);
    logic [3:0] idx;
    idx = 4'd0;
    case (cls)
      CLS_IDLE:  idx = 4'(MTIP_PRIM_IDLE);
      CLS_R_RDY: idx = 4'(MTIP_PRIM_R_RDY);
      CLS_NOS:   idx = 4'(MTIP_PRIM_NOS);
      CLS_OLS:   idx = 4'(MTIP_PRIM_OLS);
      CLS_LR:    idx = 4'(MTIP_PRIM_LR);
      CLS_LRR:   idx = 4'(MTIP_PRIM_LRR);
      CLS_LIP:   idx = 4'(MTIP_PRIM_LIP);
      default:   idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/fc1_prim_detect_if.sv
// FC-1 receive word bus into the primitive detector and its delay-matched outputs.
interface fc1_prim_detect_if;
  import mtip_if_cfg::*;

  logic [FC1_WORD_W-1:0] iRX_FC1_DATA;
  logic                  iRX_FC1_KCHN;
  logic                  iRX_FC1_ERR;
  logic [FC1_WORD_W-1:0] oRX_FC1_DATA;
  logic                  oRX_FC1_KCHN;
  logic                  oRX_FC1_ERR;
  logic [PRIM_W-1:0]     oRX_PRIMITIVE;
  logic                  oUNREC_OS_EN;

  modport master (
    output iRX_FC1_DATA, iRX_FC1_KCHN, iRX_FC1_ERR,
    input  oRX_FC1_DATA, oRX_FC1_KCHN, oRX_FC1_ERR, oRX_PRIMITIVE, oUNREC_OS_EN
  );

  modport slave (
    input  iRX_FC1_DATA, iRX_FC1_KCHN, iRX_FC1_ERR,
    output oRX_FC1_DATA, oRX_FC1_KCHN, oRX_FC1_ERR, oRX_PRIMITIVE, oUNREC_OS_EN
  );
endinterface

// File: rtl/fc1_os_classify.sv
// Combinational ordered-set decoder: maps a registered receive word to a class
// code and flags SOF/EOF delimiters.
module fc1_os_classify
  import mtip_if_cfg::*;
(
  input  logic [FC1_WORD_W-1:0] word,
  input  logic                  kChar,
  input  logic                  err,
  output fc1OsClass_t           osClass_c,
  output logic                  isDelim_c
);

  always_comb begin
    osClass_c = CLS_NONE;
    isDelim_c = 1'b0;
    // Only error-free words led by K28.5 can be ordered sets
    if (kChar && !err && (word[31:24] == K28_5)) begin
      case (word)
        OS_IDLE:  osClass_c = CLS_IDLE;
        OS_R_RDY: osClass_c = CLS_R_RDY;
        OS_NOS:   osClass_c = CLS_NOS;
        OS_OLS:   osClass_c = CLS_OLS;
        OS_LR:    osClass_c = CLS_LR;
        OS_LRR:   osClass_c = CLS_LRR;
        OS_LIP:   osClass_c = CLS_LIP;
        default:  osClass_c = CLS_NONE;
      endcase
      for (int i = 0; i < int'(NUM_DELIM); i++) begin
        if (word == FC1_DELIM[i]) isDelim_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc1_prim_detect.sv
// FC-1 primitive detector: two-stage pipeline that flags primitive signals on
// every occurrence and primitive sequences after SEQ_COUNT identical words.
module fc1_prim_detect
  import mtip_if_cfg::*;
#(
  parameter int unsigned SEQ_COUNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  fc1_prim_detect_if.slave   rx
);

  localparam logic [CNT_W-1:0] SEQ_MAX = CNT_W'(SEQ_COUNT);

  logic [FC1_WORD_W-1:0] dataS1;
  logic                  kchnS1;
  logic                  errS1;
  fc1OsClass_t           clsS1;
  logic                  delimS1;

  logic [CNT_W-1:0]      runCnt;
  fc1OsClass_t           runClass;
  logic [CNT_W-1:0]      cntNext;
  fc1OsClass_t           classNext;
  logic [PRIM_W-1:0]     primNext;
  logic                  unrecNext;

  // Stage 1: register the raw receive word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataS1 <= '0;
      kchnS1 <= 1'b0;
      errS1  <= 1'b0;
    end else begin
      dataS1 <= rx.iRX_FC1_DATA;
      kchnS1 <= rx.iRX_FC1_KCHN;
      errS1  <= rx.iRX_FC1_ERR;
    end
  end

  fc1_os_classify u_classify (
    .word      (dataS1),
    .kChar     (kchnS1),
    .err       (errS1),
    .osClass_c (clsS1),
    .isDelim_c (delimS1)
  );

  // Run tracking and primitive vector for the word in stage 1
  always_comb begin
    cntNext   = '0;
    classNext = CLS_NONE;
    primNext  = '0;
    unrecNext = 1'b0;
    if (isSeqClass(clsS1)) begin
      classNext = clsS1;
      if (clsS1 == runClass) begin
        cntNext = (runCnt >= SEQ_MAX) ? SEQ_MAX : runCnt + CNT_W'(1);
      end else begin
        cntNext = CNT_W'(1);
      end
      if (cntNext == SEQ_MAX) primNext[primIndex(clsS1)] = 1'b1;
    end else if (clsS1 != CLS_NONE) begin
      primNext[primIndex(clsS1)] = 1'b1;
    end
    unrecNext = kchnS1 && !errS1 && (dataS1[31:24] == K28_5) &&
                (clsS1 == CLS_NONE) && !delimS1;
  end

  // Stage 2: registered outputs, delay-matched to the primitive vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runCnt           <= '0;
      runClass         <= CLS_NONE;
      rx.oRX_FC1_DATA  <= '0;
      rx.oRX_FC1_KCHN  <= 1'b0;
      rx.oRX_FC1_ERR   <= 1'b0;
      rx.oRX_PRIMITIVE <= '0;
      rx.oUNREC_OS_EN  <= 1'b0;
    end else begin
      runCnt           <= cntNext;
      runClass         <= classNext;
      rx.oRX_FC1_DATA  <= dataS1;
      rx.oRX_FC1_KCHN  <= kchnS1;
      rx.oRX_FC1_ERR   <= errS1;
      rx.oRX_PRIMITIVE <= primNext;
      rx.oUNREC_OS_EN  <= unrecNext;
    end
  end

endmodule

// File: tb/tb_fc1_prim_detect.sv
// Randomized and directed bench for fc1_prim_detect against a history-based
// reference model of ordered-set recognition.
module tb_fc1_prim_detect;

  localparam int unsigned SEQ_N = 3;

  localparam logic [31:0] W_IDLE  = 32'hBC95B5B5;
  localparam logic [31:0] W_RRDY  = 32'hBC954A4A;
  localparam logic [31:0] W_NOS   = 32'hBC55BF45;
  localparam logic [31:0] W_OLS   = 32'hBC358A55;
  localparam logic [31:0] W_LR    = 32'hBC49BF49;
  localparam logic [31:0] W_LRR   = 32'hBC35BF49;
  localparam logic [31:0] W_LIP   = 32'hBC15F7F7;
  localparam logic [31:0] W_SOFI3 = 32'hBCB55656;
  localparam logic [31:0] W_FILL  = 32'h12345678;

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        e;
  } fcw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nErr = 0;

  fcw_t        hist[$];
  logic [31:0] expData;
  logic        expK;
  logic        expE;
  logic [11:0] expPrim;
  logic        expUnrec;

  logic [31:0] delimTab [14] = '{
    32'hBCB51717, 32'hBCB55757, 32'hBCB53737, 32'hBCB55555, 32'hBCB53535,
    32'hBCB55656, 32'hBCB53636, 32'hBCB55858, 32'hBC957575, 32'hBCB57575,
    32'hBC95D5D5, 32'hBCB5D5D5, 32'hBC95F5F5, 32'hBCB5F5F5
  };
  logic [31:0] primTab [7] = '{W_IDLE, W_RRDY, W_NOS, W_OLS, W_LR, W_LRR, W_LIP};

  fc1_prim_detect_if rx ();

  fc1_prim_detect #(.SEQ_COUNT(SEQ_N)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx)
  );

  always #5 clk = ~clk;

  // 0 = not a primitive, 1..7 = IDLE, R_RDY, NOS, OLS, LR, LRR, LIP
  function automatic int clsOf(input fcw_t w);
    if (!w.k || w.e || w.d[31:24] != 8'hBC) return 0;
    for (int i = 0; i < 7; i++) if (w.d == primTab[i]) return i + 1;
    return 0;
  endfunction

  // Outputs visible now belong to the second-newest word captured since reset
  function automatic void computeExp();
    fcw_t w;
    int   c, n, i;
    bit   dl;
    expData = '0; expK = 1'b0; expE = 1'b0; expPrim = '0; expUnrec = 1'b0;
    if (hist.size() < 2) return;
    i = hist.size() - 2;
    w = hist[i];
    c = clsOf(w);
    expData = w.d; expK = w.k; expE = w.e;
    if (c == 1 || c == 2) begin
      expPrim[c-1] = 1'b1;
    end else if (c >= 3) begin
      n = 0;
      for (int j = i; j >= 0 && n < int'(SEQ_N); j--) begin
        if (clsOf(hist[j]) != c) break;
        n++;
      end
      if (n >= int'(SEQ_N)) expPrim[c-1] = 1'b1;
    end
    dl = 1'b0;
    foreach (delimTab[j]) if (w.d == delimTab[j]) dl = 1'b1;
    expUnrec = w.k && !w.e && (w.d[31:24] == 8'hBC) && (c == 0) && !dl;
  endfunction

  task automatic step(input logic [31:0] d, input logic k, input logic e);
    rx.iRX_FC1_DATA = d;
    rx.iRX_FC1_KCHN = k;
    rx.iRX_FC1_ERR  = e;
    @(posedge clk);
    if (!rst) hist.push_back('{d: d, k: k, e: e});
    @(negedge clk);
    computeExp();
  endtask

  task automatic test_reset();
    nCmp++;
    if (rx.oRX_PRIMITIVE !== 12'h000) begin nErr++; $display("FAIL reset_prim: got %h expected 000", rx.oRX_PRIMITIVE); end
    nCmp++;
    if (rx.oUNREC_OS_EN !== 1'b0) begin nErr++; $display("FAIL reset_unrec: got %b expected 0", rx.oUNREC_OS_EN); end
    nCmp++;
    if (rx.oRX_FC1_DATA !== 32'h0) begin nErr++; $display("FAIL reset_data: got %h expected 0", rx.oRX_FC1_DATA); end
    nCmp++;
    if ({rx.oRX_FC1_KCHN, rx.oRX_FC1_ERR} !== 2'b00) begin nErr++; $display("FAIL reset_kerr: got %b expected 00", {rx.oRX_FC1_KCHN, rx.oRX_FC1_ERR}); end
  endtask

  task automatic test_nos_run();
    logic [31:0] seq [10] = '{W_NOS, W_NOS, W_NOS, W_NOS, W_NOS, W_NOS, W_IDLE, W_FILL, W_FILL, W_FILL};
    int hiCnt = 0, firstHi = -1, idleAt = -1;
    for (int t = 0; t < 10; t++) begin
      step(seq[t], seq[t][31:24] == 8'hBC, 1'b0);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL nos_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      if (rx.oRX_PRIMITIVE[2]) begin hiCnt++; if (firstHi < 0) firstHi = t; end
      if (rx.oRX_PRIMITIVE[0] && idleAt < 0) idleAt = t;
    end
    nCmp++;
    if (hiCnt != 4) begin nErr++; $display("FAIL nos_len: got %0d expected 4", hiCnt); end
    nCmp++;
    if (firstHi != 3) begin nErr++; $display("FAIL nos_first: got %0d expected 3", firstHi); end
    nCmp++;
    if (idleAt != 7) begin nErr++; $display("FAIL idle_pulse: got %0d expected 7", idleAt); end
  endtask

  task automatic test_lr_broken();
    logic [31:0] seq [8] = '{W_LR, W_LR, W_IDLE, W_LR, W_LR, W_LR, W_FILL, W_FILL};
    int firstHi = -1;
    for (int t = 0; t < 8; t++) begin
      step(seq[t], seq[t][31:24] == 8'hBC, 1'b0);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL lr_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      if (rx.oRX_PRIMITIVE[4] && firstHi < 0) firstHi = t;
    end
    nCmp++;
    if (firstHi != 6) begin nErr++; $display("FAIL lr_first: got %0d expected 6", firstHi); end
  endtask

  task automatic test_err_break();
    logic [31:0] seq [7] = '{W_NOS, W_NOS, W_NOS, W_NOS, W_NOS, W_FILL, W_FILL};
    logic        ev  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int firstHi = -1;
    for (int t = 0; t < 7; t++) begin
      step(seq[t], seq[t][31:24] == 8'hBC, ev[t]);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL err_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      nCmp++;
      if (rx.oRX_FC1_ERR !== expE) begin nErr++; $display("FAIL err_delay step %0d: got %b expected %b", t, rx.oRX_FC1_ERR, expE); end
      if (rx.oRX_PRIMITIVE[2] && firstHi < 0) firstHi = t;
    end
    nCmp++;
    if (firstHi != 5) begin nErr++; $display("FAIL err_first: got %0d expected 5", firstHi); end
  endtask

  task automatic test_seq_switch();
    logic [31:0] seq [10] = '{W_OLS, W_OLS, W_OLS, W_OLS, W_LRR, W_LRR, W_LRR, W_LRR, W_FILL, W_FILL};
    int lastOls = -1, firstLrr = -1, multi = 0;
    for (int t = 0; t < 10; t++) begin
      step(seq[t], seq[t][31:24] == 8'hBC, 1'b0);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL switch_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      if (rx.oRX_PRIMITIVE[3]) lastOls = t;
      if (rx.oRX_PRIMITIVE[5] && firstLrr < 0) firstLrr = t;
      if ($countones(rx.oRX_PRIMITIVE) > 1) multi++;
    end
    nCmp++;
    if (firstLrr - lastOls - 1 != int'(SEQ_N) - 1) begin nErr++; $display("FAIL switch_gap: got %0d expected %0d", firstLrr - lastOls - 1, SEQ_N - 1); end
    nCmp++;
    if (multi != 0) begin nErr++; $display("FAIL switch_onehot: got %0d expected 0", multi); end
  endtask

  task automatic test_unrec();
    logic [31:0] seq [6] = '{32'hBC000000, W_FILL, W_SOFI3, W_FILL, W_IDLE, W_FILL};
    logic        kv  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        want[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      step(seq[t], kv[t], 1'b0);
      nCmp++;
      if (rx.oUNREC_OS_EN !== want[t]) begin nErr++; $display("FAIL unrec step %0d: got %b expected %b", t, rx.oUNREC_OS_EN, want[t]); end
      nCmp++;
      if (rx.oUNREC_OS_EN !== expUnrec) begin nErr++; $display("FAIL unrec_model step %0d: got %b expected %b", t, rx.oUNREC_OS_EN, expUnrec); end
    end
  endtask

  task automatic test_reset_mid();
    int firstHi = -1;
    for (int t = 0; t < 5; t++) step(W_LIP, 1'b1, 1'b0);
    nCmp++;
    if (rx.oRX_PRIMITIVE !== 12'h040) begin nErr++; $display("FAIL lip_held: got %h expected 040", rx.oRX_PRIMITIVE); end
    rst = 1'b1;
    #1;
    nCmp++;
    if (rx.oRX_PRIMITIVE !== 12'h000) begin nErr++; $display("FAIL async_rst: got %h expected 000", rx.oRX_PRIMITIVE); end
    hist.delete();
    step(W_LIP, 1'b1, 1'b0);
    step(W_LIP, 1'b1, 1'b0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step((t < 3) ? W_LIP : W_FILL, t < 3, 1'b0);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL relip_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      if (rx.oRX_PRIMITIVE[6] && firstHi < 0) firstHi = t;
    end
    nCmp++;
    if (firstHi != 3) begin nErr++; $display("FAIL relip_first: got %0d expected 3", firstHi); end
  endtask

  task automatic test_random();
    logic [31:0] w = W_FILL;
    logic        k = 1'b0;
    logic        e;
    int          r;
    for (int t = 0; t < 400; t++) begin
      if (t == 0 || $urandom_range(9) < 4) begin
        r = $urandom_range(10);
        if (r < 7) begin w = primTab[r]; k = 1'b1; end
        else if (r == 7) begin w = 32'hBC000000 | 32'($urandom_range(32'h00FFFFFF)); k = 1'b1; end
        else if (r == 8) begin w = delimTab[$urandom_range(13)]; k = 1'b1; end
        else if (r == 9) begin w = $urandom; k = 1'b0; end
        else begin w = $urandom; k = 1'($urandom_range(1)); end
      end
      e = ($urandom_range(11) == 0);
      step(w, k, e);
      nCmp++;
      if (rx.oRX_PRIMITIVE !== expPrim) begin nErr++; $display("FAIL rand_prim step %0d: got %h expected %h", t, rx.oRX_PRIMITIVE, expPrim); end
      nCmp++;
      if (rx.oUNREC_OS_EN !== expUnrec) begin nErr++; $display("FAIL rand_unrec step %0d: got %b expected %b", t, rx.oUNREC_OS_EN, expUnrec); end
      nCmp++;
      if ({rx.oRX_FC1_DATA, rx.oRX_FC1_KCHN, rx.oRX_FC1_ERR} !== {expData, expK, expE})
        begin nErr++; $display("FAIL rand_delay step %0d: got %h/%b/%b expected %h/%b/%b", t, rx.oRX_FC1_DATA, rx.oRX_FC1_KCHN, rx.oRX_FC1_ERR, expData, expK, expE); end
    end
  endtask

  initial begin
    rx.iRX_FC1_DATA = '0;
    rx.iRX_FC1_KCHN = 1'b0;
    rx.iRX_FC1_ERR  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    hist.delete();
    test_nos_run();
    test_lr_broken();
    test_err_break();
    test_seq_switch();
    test_unrec();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
